// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage. It issues word fetches over a req/ack handshake
// and delivers each instruction with its PC to decode through a one-entry valid/ready register.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] br_target,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_ACK
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        drop;
    logic        slot_free;
    logic        capture;
    logic        redirect_active;
    logic [31:0] target_aligned;

    assign imem_addr       = pc;
    assign slot_free       = !if_valid || if_ready;
    assign redirect_active = redirect && (state != IDLE);
    assign target_aligned  = br_target & ~32'd3;

    // Once a request is on the bus it stays up until acked; a redirect only marks it for discard.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = !stall && !redirect && slot_free;
                if (imem_req && imem_ack) begin
                    capture = 1'b1;
                end else if (imem_req) begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = FETCH;
                    capture    = !drop && !redirect;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= 32'd0;
            if_pc    <= 32'd0;
        end else begin
            state <= state_next;
            if (redirect_active) begin
                pc       <= target_aligned;
                if_valid <= 1'b0;
            end else if (capture) begin
                pc       <= pc_plus4;
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end else if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
            // Repeated redirects while a discard is pending still cost only one dropped ack.
            if (state == WAIT_ACK) begin
                if (imem_ack) begin
                    drop <= 1'b0;
                end else if (redirect) begin
                    drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed handshake scenarios plus a randomized run
// checked against a stream model of the expected (pc, instruction) sequence seen by decode.
module tb_pc_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] br_target = 32'd0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // External PC+4 adder.
    assign pc_plus4 = pc + 32'd4;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_plus4(pc_plus4), .br_target(br_target),
        .redirect(redirect), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    // Leaves rst_n low after three reset edges, at a negedge; caller releases it.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'd0; if_ready = 1'b1; br_target = 32'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (pc !== 32'h3000) begin errors++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h3000); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", if_valid); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", if_instr); end
        checks++; if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_ifpc got %h want 0", if_pc); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL release_c1_req got %b want 0", imem_req); end
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_c2_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL release_c2_addr got %h want %h", imem_addr, 32'h3000); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        do_reset(); rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i > 0) begin
                e = 32'h3000 + 32'(4 * (i - 1));
                checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL zw_valid got %b want 1", if_valid); end
                checks++; if (if_pc !== e) begin errors++; $display("[TB] FAIL zw_ifpc got %h want %h", if_pc, e); end
                checks++; if (if_instr !== (e ^ K)) begin errors++; $display("[TB] FAIL zw_instr got %h want %h", if_instr, e ^ K); end
            end
            e = 32'h3000 + 32'(4 * i);
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL zw_req got %b want 1", imem_req); end
            checks++; if (imem_addr !== e) begin errors++; $display("[TB] FAIL zw_addr got %h want %h", imem_addr, e); end
            imem_ack = 1'b1; imem_rdata = imem_addr ^ K;
            @(negedge clk);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_wait_backpressure();
        do_reset(); rst_n = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            #1;
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ws_req got %b want 1", imem_req); end
            checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL ws_addr_held got %h want %h", imem_addr, 32'h3000); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL ws_valid_early got %b want 0", if_valid); end
            imem_ack = (w == 2); imem_rdata = 32'h3000 ^ K;
            @(negedge clk);
        end
        imem_ack = 1'b0; if_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            #1;
            checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid got %b want 1", if_valid); end
            checks++; if (if_pc !== 32'h3000) begin errors++; $display("[TB] FAIL bp_ifpc got %h want %h", if_pc, 32'h3000); end
            checks++; if (if_instr !== (32'h3000 ^ K)) begin errors++; $display("[TB] FAIL bp_instr got %h want %h", if_instr, 32'h3000 ^ K); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req got %b want 0", imem_req); end
            @(negedge clk);
        end
        if_ready = 1'b1;
        #1;
        checks++; if (if_pc !== 32'h3000) begin errors++; $display("[TB] FAIL bp_release_ifpc got %h want %h", if_pc, 32'h3000); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL bp_release_addr got %h want %h", imem_addr, 32'h3004); end
        imem_ack = 1'b1; imem_rdata = 32'h3004 ^ K;
        @(negedge clk);
        imem_ack = 1'b0; if_ready = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_valid got %b want 1", if_valid); end
        checks++; if (if_pc !== 32'h3004) begin errors++; $display("[TB] FAIL bp_next_ifpc got %h want %h", if_pc, 32'h3004); end
        checks++; if (if_instr !== (32'h3004 ^ K)) begin errors++; $display("[TB] FAIL bp_next_instr got %h want %h", if_instr, 32'h3004 ^ K); end
        if_ready = 1'b1;
    endtask

    task automatic test_redirect_outstanding();
        do_reset(); rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1; imem_ack = 1'b1; imem_rdata = imem_addr ^ K;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h3008) begin errors++; $display("[TB] FAIL ro_addr got %h want %h", imem_addr, 32'h3008); end
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ro_pending_req got %b want 1", imem_req); end
        redirect = 1'b1; br_target = 32'h0000_4002;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (pc !== 32'h4000) begin errors++; $display("[TB] FAIL ro_pc got %h want %h", pc, 32'h4000); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL ro_valid_pre got %b want 0", if_valid); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL ro_discard got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ro_new_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h4000) begin errors++; $display("[TB] FAIL ro_new_addr got %h want %h", imem_addr, 32'h4000); end
        imem_ack = 1'b1; imem_rdata = 32'h4000 ^ K;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL ro_valid got %b want 1", if_valid); end
        checks++; if (if_pc !== 32'h4000) begin errors++; $display("[TB] FAIL ro_ifpc got %h want %h", if_pc, 32'h4000); end
        checks++; if (if_instr !== (32'h4000 ^ K)) begin errors++; $display("[TB] FAIL ro_instr got %h want %h", if_instr, 32'h4000 ^ K); end
    endtask

    task automatic test_redirect_ack_stall();
        do_reset(); rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL ras_addr got %h want %h", imem_addr, 32'h3000); end
        @(negedge clk);
        redirect = 1'b1; stall = 1'b1; br_target = 32'h0000_5000;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ras_wait_req got %b want 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #1;
            checks++; if (pc !== 32'h5000) begin errors++; $display("[TB] FAIL ras_pc got %h want %h", pc, 32'h5000); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL ras_valid got %b want 0", if_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ras_stall_req got %b want 0", imem_req); end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ras_unstall_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h5000) begin errors++; $display("[TB] FAIL ras_unstall_addr got %h want %h", imem_addr, 32'h5000); end
        imem_ack = 1'b1; imem_rdata = 32'h5000 ^ K;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (if_pc !== 32'h5000) begin errors++; $display("[TB] FAIL ras_ifpc got %h want %h", if_pc, 32'h5000); end
        checks++; if (if_instr !== (32'h5000 ^ K)) begin errors++; $display("[TB] FAIL ras_instr got %h want %h", if_instr, 32'h5000 ^ K); end
    endtask

    task automatic test_wrap();
        do_reset(); rst_n = 1'b1;
        @(negedge clk);
        redirect = 1'b1; br_target = 32'hFFFF_FFFC;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL wrap_redir_req got %b want 0", imem_req); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr0 got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        imem_ack = 1'b1; imem_rdata = imem_addr ^ K;
        @(negedge clk);
        #1;
        checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_ifpc0 got %h want %h", if_pc, 32'hFFFF_FFFC); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr1 got %h want 0", imem_addr); end
        imem_rdata = imem_addr ^ K;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_ifpc1 got %h want 0", if_pc); end
        checks++; if (if_instr !== K) begin errors++; $display("[TB] FAIL wrap_instr1 got %h want %h", if_instr, K); end
    endtask

    // Model: decode must see consecutive word addresses, restarting at each aligned redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] hold_addr;
        logic        pending;
        logic        hold_ok;
        int          lat;
        int          accepted;
        exp_pc = 32'h3000; hold_addr = 32'd0; pending = 1'b0; hold_ok = 1'b0; lat = 0; accepted = 0;
        do_reset(); rst_n = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            stall = ($urandom % 4) == 0;
            redirect = ($urandom % 16) == 0;
            if_ready = ($urandom % 3) != 0;
            br_target = 32'h6000 + ($urandom & 32'hFF);
            imem_ack = 1'b0;
            #1;
            if (if_valid && if_ready) begin
                accepted++;
                checks++; if (if_pc !== exp_pc) begin errors++; $display("[TB] FAIL rnd_ifpc got %h want %h", if_pc, exp_pc); end
                checks++; if (if_instr !== (exp_pc ^ K)) begin errors++; $display("[TB] FAIL rnd_instr got %h want %h", if_instr, exp_pc ^ K); end
                exp_pc = exp_pc + 32'd4;
            end
            if (pending) begin
                checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rnd_req_dropped got %b want 1", imem_req); end
                if (hold_ok) begin
                    checks++; if (imem_addr !== hold_addr) begin errors++; $display("[TB] FAIL rnd_addr_held got %h want %h", imem_addr, hold_addr); end
                end
            end
            if (imem_req) begin
                if (!pending) begin
                    pending = 1'b1; hold_ok = 1'b1; hold_addr = imem_addr; lat = $urandom_range(0, 3);
                end
                imem_ack = (lat == 0);
                imem_rdata = hold_addr ^ K;
                if (lat > 0) lat--;
                if (imem_ack) pending = 1'b0;
            end else begin
                imem_ack = ($urandom % 4) == 0;
                imem_rdata = $urandom;
            end
            if (redirect) begin
                exp_pc = br_target & ~32'd3;
                hold_ok = 1'b0;
            end
            @(negedge clk);
        end
        redirect = 1'b0; imem_ack = 1'b0; stall = 1'b0; if_ready = 1'b1;
        checks++; if (accepted < 200) begin errors++; $display("[TB] FAIL rnd_progress got %0d want >= 200", accepted); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_backpressure();
        test_redirect_outstanding();
        test_redirect_ack_stall();
        test_wrap();
        test_random();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
